// File: rtl/t05_huff_pkg.sv
// Shared types and constants for the Huffman min-pair selection stage.
// Node ids: characters {0,c}, sum nodes {1,0,i}, NULL never collides with either.
package t05_huff_pkg;

   localparam int HIST_W = 32;
   localparam int SUM_W  = 46;

   localparam logic [8:0] NULL_NODE = 9'b110000000;

   typedef enum logic [2:0] {
      IDLE,
      SCAN_CHAR,
      SCAN_NODE,
      FLUSH,
      EMIT
   } fl_state_t;

   function automatic logic [8:0] make_id(input logic is_sum, input logic [7:0] idx);
      return is_sum ? {2'b10, idx[6:0]} : {1'b0, idx};
   endfunction

endpackage

// File: rtl/t05_min_pair_finder_if.sv
// Memory-read, control and result bundle between the pair finder and its neighbours.
interface t05_min_pair_finder_if;
   import t05_huff_pkg::*;

   logic              fl_start;
   logic              fl_clear;
   logic              fl_ack;
   logic [6:0]        node_count;
   logic [7:0]        hist_addr;
   logic [HIST_W-1:0] hist_rdata;
   logic [6:0]        node_addr;
   logic [SUM_W-1:0]  node_rdata;
   logic [8:0]        least1;
   logic [8:0]        least2;
   logic [SUM_W-1:0]  sum;
   logic              fl_valid;
   logic              fl_last;
   logic              fl_busy;

   modport master (
      input  fl_start, fl_clear, fl_ack, node_count, hist_rdata, node_rdata,
      output hist_addr, node_addr, least1, least2, sum, fl_valid, fl_last, fl_busy
   );

   modport slave (
      output fl_start, fl_clear, fl_ack, node_count, hist_rdata, node_rdata,
      input  hist_addr, node_addr, least1, least2, sum, fl_valid, fl_last, fl_busy
   );

endinterface

// File: rtl/t05_min2_tracker.sv
// Registered tracker of the two smallest weights seen since the last clear.
// Strict compares keep the earlier entry on ties.
module t05_min2_tracker
   import t05_huff_pkg::*;
#(
   parameter int W = SUM_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         cand_valid,
   input  logic [W-1:0] weight,
   input  logic [8:0]   id,
   output logic [W-1:0] min1_w,
   output logic [W-1:0] min2_w,
   output logic [8:0]   min1_id,
   output logic [8:0]   min2_id
);

   // NOTE: non-blocking assignments let min2 take the old min1 in the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         min1_w  <= '1;
         min2_w  <= '1;
         min1_id <= NULL_NODE;
         min2_id <= NULL_NODE;
      end else if (cand_valid) begin
         if (weight < min1_w) begin
            min2_w  <= min1_w;
            min2_id <= min1_id;
            min1_w  <= weight;
            min1_id <= id;
         end else if (weight < min2_w) begin
            min2_w  <= weight;
            min2_id <= id;
         end
      end
   end

endmodule

// File: rtl/t05_min_pair_finder.sv
// Scans histogram then sum nodes, tracks the two lightest unused entries and
// presents them with their saturated sum until the tree builder acknowledges.
module t05_min_pair_finder
   import t05_huff_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   t05_min_pair_finder_if.master bus
);

   fl_state_t        state, state_nxt;
   logic [255:0]     char_used;
   logic [127:0]     node_used;
   logic [6:0]       n_reg;
   logic [7:0]       hist_addr;
   logic [6:0]       node_addr;
   logic             eval_char, eval_node;
   logic [7:0]       eval_idx;
   logic             start_pass;
   logic             cand_valid;
   logic [SUM_W-1:0] cand_w;
   logic [8:0]       cand_id;
   logic [SUM_W-1:0] min1_w, min2_w;
   logic [8:0]       min1_id, min2_id;
   logic [SUM_W:0]   raw_sum;

   assign start_pass = (state == IDLE) && bus.fl_start;

   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_nxt = state;
      unique case (state)
         IDLE:      if (bus.fl_start) state_nxt = SCAN_CHAR;
         SCAN_CHAR: if (hist_addr == 8'd255) state_nxt = (n_reg == 7'd0) ? FLUSH : SCAN_NODE;
         SCAN_NODE: if (node_addr == n_reg - 7'd1) state_nxt = FLUSH;
         FLUSH:     state_nxt = EMIT;
         EMIT:      if (bus.fl_ack) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the used-bitmaps are reset because every pass reads them.
         state     <= IDLE;
         char_used <= '0;
         node_used <= '0;
         n_reg     <= '0;
         hist_addr <= '0;
         node_addr <= '0;
         eval_char <= 1'b0;
         eval_node <= 1'b0;
         eval_idx  <= '0;
      end else begin
         state     <= state_nxt;
         eval_char <= (state == SCAN_CHAR);
         eval_node <= (state == SCAN_NODE);
         eval_idx  <= (state == SCAN_NODE) ? {1'b0, node_addr} : hist_addr;
         unique case (state)
            IDLE: begin
               if (bus.fl_clear) begin
                  char_used <= '0;
                  node_used <= '0;
               end
               if (bus.fl_start) begin
                  hist_addr <= '0;
                  node_addr <= '0;
                  n_reg     <= bus.node_count;
               end
            end
            SCAN_CHAR: hist_addr <= hist_addr + 8'd1;
            SCAN_NODE: if (node_addr != n_reg - 7'd1) node_addr <= node_addr + 7'd1;
            EMIT: if (bus.fl_ack) begin
               if (min1_id != NULL_NODE) begin
                  if (min1_id[8]) node_used[min1_id[6:0]] <= 1'b1;
                  else            char_used[min1_id[7:0]] <= 1'b1;
               end
               if (min2_id != NULL_NODE) begin
                  if (min2_id[8]) node_used[min2_id[6:0]] <= 1'b1;
                  else            char_used[min2_id[7:0]] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Read data lands one cycle after its address, so evaluation lags the scan.
   always_comb begin
      cand_valid = 1'b0;
      cand_w     = '0;
      cand_id    = NULL_NODE;
      if (eval_char) begin
         cand_w     = {{(SUM_W-HIST_W){1'b0}}, bus.hist_rdata};
         cand_id    = make_id(1'b0, eval_idx);
         cand_valid = (bus.hist_rdata != '0) && !char_used[eval_idx];
      end else if (eval_node) begin
         cand_w     = bus.node_rdata;
         cand_id    = make_id(1'b1, eval_idx);
         cand_valid = !node_used[eval_idx[6:0]];
      end
   end

   t05_min2_tracker #(.W(SUM_W)) u_tracker (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (start_pass),
      .cand_valid (cand_valid),
      .weight     (cand_w),
      .id         (cand_id),
      .min1_w     (min1_w),
      .min2_w     (min2_w),
      .min1_id    (min1_id),
      .min2_id    (min2_id)
   );

   assign raw_sum = {1'b0, min1_w} + {1'b0, min2_w};

   always_comb begin
      bus.least1   = NULL_NODE;
      bus.least2   = NULL_NODE;
      bus.sum      = '0;
      bus.fl_valid = 1'b0;
      bus.fl_last  = 1'b0;
      if (state == EMIT) begin
         bus.fl_valid = 1'b1;
         bus.least1   = min1_id;
         bus.least2   = min2_id;
         if (min1_id == NULL_NODE) begin
            bus.fl_last = 1'b1;
         end else if (min2_id == NULL_NODE) begin
            bus.fl_last = 1'b1;
            bus.sum     = min1_w;
         end else begin
            bus.sum = raw_sum[SUM_W] ? '1 : raw_sum[SUM_W-1:0];
         end
      end
   end

   assign bus.fl_busy   = (state == SCAN_CHAR) || (state == SCAN_NODE) || (state == FLUSH);
   assign bus.hist_addr = hist_addr;
   assign bus.node_addr = node_addr;

endmodule

// File: tb/tb_t05_min_pair_finder.sv
// Directed bench for the min-pair finder: timing, tie order, reduced sets,
// mid-scan reset and held acknowledge, against hand-computed expectations.
module tb_t05_min_pair_finder;
   import t05_huff_pkg::*;

   localparam logic [8:0] NUL = 9'h180;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [HIST_W-1:0] hist_mem [256];
   logic [SUM_W-1:0]  node_mem [128];

   t05_min_pair_finder_if bus();

   t05_min_pair_finder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      bus.hist_rdata <= hist_mem[bus.hist_addr];
      bus.node_rdata <= node_mem[bus.node_addr];
   end

   function automatic logic [66:0] outs();
      return {bus.least1, bus.least2, bus.sum, bus.fl_valid, bus.fl_last, bus.fl_busy};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) hist_mem[i] = '0;
      for (int i = 0; i < 128; i++) node_mem[i] = '0;
   endtask

   // Called at a negedge; start is sampled at the coming edge (cycle 0).
   task automatic do_pass(input logic with_clear, output int cyc,
                          output logic [7:0] a1, output logic [7:0] a256, output logic bz);
      bus.fl_start = 1'b1;
      bus.fl_clear = with_clear;
      @(negedge clk);
      bus.fl_start = 1'b0;
      bus.fl_clear = 1'b0;
      cyc  = 1;
      a1   = bus.hist_addr;
      a256 = 8'h00;
      bz   = 1'b0;
      while (!bus.fl_valid && cyc < 600) begin
         @(negedge clk);
         cyc++;
         if (cyc == 256) a256 = bus.hist_addr;
         if (cyc == 257 + int'(bus.node_count)) bz = bus.fl_busy;
      end
   endtask

   task automatic do_ack();
      bus.fl_ack = 1'b1;
      @(negedge clk);
      bus.fl_ack = 1'b0;
   endtask

   task automatic test_reset();
      bus.fl_start = 1'b0; bus.fl_clear = 1'b0; bus.fl_ack = 1'b0; bus.node_count = '0;
      clear_mem();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({outs(), bus.hist_addr, bus.node_addr} !== {NUL, NUL, 46'd0, 3'b000, 8'd0, 7'd0}) begin
         n_fail++;
         $display("FAIL reset_values: got %h expected %h", {outs(), bus.hist_addr, bus.node_addr},
                  {NUL, NUL, 46'd0, 3'b000, 8'd0, 7'd0});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int cyc; logic [7:0] a1, a256; logic bz;
      clear_mem();
      hist_mem[8'h41] = 5; hist_mem[8'h42] = 3; hist_mem[8'h43] = 9;
      bus.node_count = 7'd0;
      do_pass(1'b1, cyc, a1, a256, bz);
      n_checks++;
      if (outs() !== {9'h042, 9'h041, 46'd8, 3'b100}) begin
         n_fail++; $display("FAIL basic_pair: got %h expected %h", outs(), {9'h042, 9'h041, 46'd8, 3'b100});
      end
      n_checks++;
      if (cyc !== 258) begin n_fail++; $display("FAIL basic_valid_cycle: got %0d expected 258", cyc); end
      n_checks++;
      if ({a1, a256, bz} !== {8'd0, 8'd255, 1'b1}) begin
         n_fail++; $display("FAIL basic_scan_timing: got %h expected %h", {a1, a256, bz}, {8'd0, 8'd255, 1'b1});
      end
      do_ack();
      n_checks++;
      if (bus.fl_valid !== 1'b0) begin n_fail++; $display("FAIL basic_ack_drop: got %b expected 0", bus.fl_valid); end
   endtask

   task automatic test_node_pass();
      int cyc; logic [7:0] a1, a256; logic bz;
      node_mem[0] = 46'd8;
      bus.node_count = 7'd1;
      do_pass(1'b0, cyc, a1, a256, bz);
      n_checks++;
      if (outs() !== {9'h100, 9'h043, 46'd17, 3'b100}) begin
         n_fail++; $display("FAIL node_pair: got %h expected %h", outs(), {9'h100, 9'h043, 46'd17, 3'b100});
      end
      n_checks++;
      if (cyc !== 259) begin n_fail++; $display("FAIL node_valid_cycle: got %0d expected 259", cyc); end
      n_checks++;
      if (bz !== 1'b1) begin n_fail++; $display("FAIL node_busy_last: got %b expected 1", bz); end
      do_ack();
   endtask

   task automatic test_tie();
      int cyc; logic [7:0] a1, a256; logic bz;
      clear_mem();
      hist_mem[8'h58] = 4; hist_mem[8'h59] = 4; node_mem[0] = 46'd4;
      bus.node_count = 7'd1;
      do_pass(1'b1, cyc, a1, a256, bz);
      n_checks++;
      if (outs() !== {9'h058, 9'h059, 46'd8, 3'b100}) begin
         n_fail++; $display("FAIL tie_pair: got %h expected %h", outs(), {9'h058, 9'h059, 46'd8, 3'b100});
      end
      do_ack();
      // node0 was used before the clear-with-start, so it must reappear now
      do_pass(1'b0, cyc, a1, a256, bz);
      n_checks++;
      if (outs() !== {9'h100, NUL, 46'd4, 3'b110}) begin
         n_fail++; $display("FAIL tie_leftover: got %h expected %h", outs(), {9'h100, NUL, 46'd4, 3'b110});
      end
      do_ack();
   endtask

   task automatic test_single();
      int cyc; logic [7:0] a1, a256; logic bz;
      logic [66:0] exp_tab [5];
      exp_tab[0] = {9'h05A, 9'h100, 46'd3,   3'b100};
      exp_tab[1] = {9'h101, 9'h102, 46'd7,   3'b100};
      exp_tab[2] = {9'h103, 9'h104, 46'd11,  3'b100};
      exp_tab[3] = {9'h105, NUL,    46'd120, 3'b110};
      exp_tab[4] = {NUL,    NUL,    46'd0,   3'b110};
      clear_mem();
      hist_mem[8'h5A] = 1;
      node_mem[0] = 2; node_mem[1] = 3; node_mem[2] = 4;
      node_mem[3] = 5; node_mem[4] = 6; node_mem[5] = 120;
      bus.node_count = 7'd6;
      for (int p = 0; p < 5; p++) begin
         do_pass(p == 0, cyc, a1, a256, bz);
         n_checks++;
         if (outs() !== exp_tab[p]) begin
            n_fail++; $display("FAIL single_pass%0d: got %h expected %h", p, outs(), exp_tab[p]);
         end
         n_checks++;
         if (cyc !== 264) begin n_fail++; $display("FAIL single_cycle%0d: got %0d expected 264", p, cyc); end
         do_ack();
      end
   endtask

   task automatic test_reset_midscan();
      int cyc; logic [7:0] a1, a256; logic bz;
      clear_mem();
      hist_mem[8'h41] = 5; hist_mem[8'h42] = 3; hist_mem[8'h43] = 9;
      bus.node_count = 7'd0;
      do_pass(1'b1, cyc, a1, a256, bz);
      do_ack();
      // A and B are now used; the reset must clear that
      bus.fl_start = 1'b1;
      @(negedge clk);
      bus.fl_start = 1'b0;
      repeat (99) @(negedge clk);
      n_checks++;
      if (bus.fl_busy !== 1'b1) begin n_fail++; $display("FAIL midscan_busy: got %b expected 1", bus.fl_busy); end
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({outs(), bus.hist_addr, bus.node_addr} !== {NUL, NUL, 46'd0, 3'b000, 8'd0, 7'd0}) begin
         n_fail++; $display("FAIL midscan_reset: got %h expected %h", {outs(), bus.hist_addr, bus.node_addr},
                            {NUL, NUL, 46'd0, 3'b000, 8'd0, 7'd0});
      end
      rst_n = 1'b1;
      @(negedge clk);
      do_pass(1'b0, cyc, a1, a256, bz);
      n_checks++;
      if ({outs(), cyc} !== {9'h042, 9'h041, 46'd8, 3'b100, 32'd258}) begin
         n_fail++; $display("FAIL midscan_restart: got %h expected %h", {outs(), cyc},
                            {9'h042, 9'h041, 46'd8, 3'b100, 32'd258});
      end
   endtask

   // Continues from the EMIT left by test_reset_midscan.
   task automatic test_hold_ack();
      int cyc; logic [7:0] a1, a256; logic bz;
      int unstable = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if (outs() !== {9'h042, 9'h041, 46'd8, 3'b100}) begin
            n_fail++; unstable++;
            if (unstable < 3) $display("FAIL hold_stable%0d: got %h expected %h", i, outs(),
                                       {9'h042, 9'h041, 46'd8, 3'b100});
         end
      end
      do_ack();
      n_checks++;
      if (bus.fl_valid !== 1'b0) begin n_fail++; $display("FAIL hold_ack_drop: got %b expected 0", bus.fl_valid); end
      // back-to-back start in the cycle right after the ack
      do_pass(1'b0, cyc, a1, a256, bz);
      n_checks++;
      if (outs() !== {9'h043, NUL, 46'd9, 3'b110}) begin
         n_fail++; $display("FAIL hold_excluded: got %h expected %h", outs(), {9'h043, NUL, 46'd9, 3'b110});
      end
      n_checks++;
      if (cyc !== 258) begin n_fail++; $display("FAIL hold_next_cycle: got %0d expected 258", cyc); end
      do_ack();
      n_checks++;
      if (outs() !== {NUL, NUL, 46'd0, 3'b000}) begin
         n_fail++; $display("FAIL hold_idle_outs: got %h expected %h", outs(), {NUL, NUL, 46'd0, 3'b000});
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_node_pass();
      test_tie();
      test_single();
      test_reset_midscan();
      test_hold_ack();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
